// File: rtl/rename_ckpt_if.sv
// Decode-to-rename-to-dispatch bundle for rename_ckpt, with writeback, commit and branch resolution.
// Inputs are sampled combinationally; rinstr_valid_o has no ready, and dispatch must take it the same cycle.
interface rename_ckpt_if #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int CKPTS     = 4
);
    localparam int AW = $clog2(ARCH_REGS);
    localparam int PW = $clog2(PHYS_REGS);
    localparam int TW = (CKPTS > 1) ? $clog2(CKPTS) : 1;

    logic          dinstr_valid_i;
    logic          dinstr_is_branch_i;
    logic          dinstr_rd_valid_i;
    logic          dinstr_rs1_valid_i;
    logic          dinstr_rs2_valid_i;
    logic [AW-1:0] dinstr_rd_idx_i;
    logic [AW-1:0] dinstr_rs1_idx_i;
    logic [AW-1:0] dinstr_rs2_idx_i;
    logic          wb_valid_i;
    logic [PW-1:0] wb_idx_i;
    logic          commit_valid_i;
    logic [PW-1:0] commit_idx_i;
    logic          br_valid_i;
    logic          br_hit_i;
    logic [TW-1:0] br_tag_i;

    logic          rinstr_valid_o;
    logic          rinstr_rd_valid_o;
    logic [PW-1:0] rinstr_rd_idx_o;
    logic [PW-1:0] rinstr_rd_old_idx_o;
    logic          rinstr_rs1_valid_o;
    logic [PW-1:0] rinstr_rs1_idx_o;
    logic          rinstr_rs1_ready_o;
    logic          rinstr_rs2_valid_o;
    logic [PW-1:0] rinstr_rs2_idx_o;
    logic          rinstr_rs2_ready_o;
    logic          rinstr_br_valid_o;
    logic [TW-1:0] rinstr_br_tag_o;
    logic          rn_full_o;

    modport slave (
        input  dinstr_valid_i, dinstr_is_branch_i, dinstr_rd_valid_i,
               dinstr_rs1_valid_i, dinstr_rs2_valid_i, dinstr_rd_idx_i,
               dinstr_rs1_idx_i, dinstr_rs2_idx_i, wb_valid_i, wb_idx_i,
               commit_valid_i, commit_idx_i, br_valid_i, br_hit_i, br_tag_i,
        output rinstr_valid_o, rinstr_rd_valid_o, rinstr_rd_idx_o,
               rinstr_rd_old_idx_o, rinstr_rs1_valid_o, rinstr_rs1_idx_o,
               rinstr_rs1_ready_o, rinstr_rs2_valid_o, rinstr_rs2_idx_o,
               rinstr_rs2_ready_o, rinstr_br_valid_o, rinstr_br_tag_o, rn_full_o
    );

    modport master (
        output dinstr_valid_i, dinstr_is_branch_i, dinstr_rd_valid_i,
               dinstr_rs1_valid_i, dinstr_rs2_valid_i, dinstr_rd_idx_i,
               dinstr_rs1_idx_i, dinstr_rs2_idx_i, wb_valid_i, wb_idx_i,
               commit_valid_i, commit_idx_i, br_valid_i, br_hit_i, br_tag_i,
        input  rinstr_valid_o, rinstr_rd_valid_o, rinstr_rd_idx_o,
               rinstr_rd_old_idx_o, rinstr_rs1_valid_o, rinstr_rs1_idx_o,
               rinstr_rs1_ready_o, rinstr_rs2_valid_o, rinstr_rs2_idx_o,
               rinstr_rs2_ready_o, rinstr_br_valid_o, rinstr_br_tag_o, rn_full_o
    );
endinterface

// File: rtl/rename_ckpt.sv
// Register rename stage: map table, free list, ready table and CKPTS branch checkpoints
// with out-of-order resolution and single-cycle mispredict recovery.
module rename_ckpt #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int CKPTS     = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    rename_ckpt_if.slave   rn
);
    localparam int AW = $clog2(ARCH_REGS);
    localparam int PW = $clog2(PHYS_REGS);
    localparam int TW = (CKPTS > 1) ? $clog2(CKPTS) : 1;

    logic [PW-1:0]        map_q   [ARCH_REGS];
    logic [PW-1:0]        map_d   [ARCH_REGS];
    logic [PW-1:0]        map_post[ARCH_REGS];
    logic [PHYS_REGS-1:0] ready_q, ready_d;
    logic [PHYS_REGS-1:0] free_q, free_d;
    logic [CKPTS-1:0]     ckv_q, ckv_d;
    logic [PW-1:0]        ckmap_q [CKPTS][ARCH_REGS];
    logic [PW-1:0]        ckmap_d [CKPTS][ARCH_REGS];
    logic [PHYS_REGS-1:0] amask_q [CKPTS];
    logic [PHYS_REGS-1:0] amask_d [CKPTS];
    // dep_q[i][j] set means slot j was taken after slot i (j is younger)
    logic [CKPTS-1:0]     dep_q   [CKPTS];
    logic [CKPTS-1:0]     dep_d   [CKPTS];

    logic          rn_full, kill, accept, rd_en, br_en;
    logic          res_valid, hit, miss;
    logic [PW-1:0] alloc_p;
    logic [TW-1:0] ck_k;
    logic [PW-1:0] rs1_idx, rs2_idx;
    logic          rs1_rdy, rs2_rdy;
    logic [CKPTS-1:0] drop;

    always_comb begin : decode
        rn_full   = (free_q == '0) || (ckv_q == '1);
        kill      = rn.br_valid_i & ~rn.br_hit_i;
        accept    = rst_ni & rn.dinstr_valid_i & ~rn_full & ~kill;
        rd_en     = accept & rn.dinstr_rd_valid_i & (rn.dinstr_rd_idx_i != '0);
        br_en     = accept & rn.dinstr_is_branch_i;
        res_valid = rn.br_valid_i & ckv_q[rn.br_tag_i];
        hit       = res_valid & rn.br_hit_i;
        miss      = res_valid & ~rn.br_hit_i;
        rs1_idx   = map_q[rn.dinstr_rs1_idx_i];
        rs2_idx   = map_q[rn.dinstr_rs2_idx_i];
        rs1_rdy   = (rn.dinstr_rs1_idx_i == '0) || ready_q[rs1_idx] ||
                    (rn.wb_valid_i && (rn.wb_idx_i == rs1_idx));
        rs2_rdy   = (rn.dinstr_rs2_idx_i == '0) || ready_q[rs2_idx] ||
                    (rn.wb_valid_i && (rn.wb_idx_i == rs2_idx));
    end

    // Lowest free physical register (0 is never free) and lowest idle slot.
    always_comb begin : encoders
        alloc_p = '0;
        for (int i = PHYS_REGS - 1; i > 0; i--) begin
            if (free_q[i]) alloc_p = PW'(i);
        end
        ck_k = '0;
        for (int i = CKPTS - 1; i >= 0; i--) begin
            if (!ckv_q[i]) ck_k = TW'(i);
        end
    end

    assign rn.rinstr_valid_o      = accept;
    assign rn.rinstr_rd_valid_o   = rd_en;
    assign rn.rinstr_rd_idx_o     = alloc_p;
    assign rn.rinstr_rd_old_idx_o = map_q[rn.dinstr_rd_idx_i];
    assign rn.rinstr_rs1_valid_o  = accept & rn.dinstr_rs1_valid_i;
    assign rn.rinstr_rs1_idx_o    = rs1_idx;
    assign rn.rinstr_rs1_ready_o  = rs1_rdy;
    assign rn.rinstr_rs2_valid_o  = accept & rn.dinstr_rs2_valid_i;
    assign rn.rinstr_rs2_idx_o    = rs2_idx;
    assign rn.rinstr_rs2_ready_o  = rs2_rdy;
    assign rn.rinstr_br_valid_o   = br_en;
    assign rn.rinstr_br_tag_o     = ck_k;
    assign rn.rn_full_o           = rn_full;

    // A branch checkpoints the map including its own rd update.
    always_comb begin : map_next
        map_post = map_q;
        if (rd_en) map_post[rn.dinstr_rd_idx_i] = alloc_p;
        map_d = miss ? ckmap_q[rn.br_tag_i] : map_post;
        ckmap_d = ckmap_q;
        if (br_en) ckmap_d[ck_k] = map_post;
    end

    always_comb begin : free_ready_next
        ready_d = ready_q;
        free_d  = free_q;
        if (rn.wb_valid_i) ready_d[rn.wb_idx_i] = 1'b1;
        if (rn.commit_valid_i && (rn.commit_idx_i != '0)) begin
            free_d[rn.commit_idx_i]  = 1'b1;
            ready_d[rn.commit_idx_i] = 1'b1;
        end
        if (rd_en) begin
            free_d[alloc_p]  = 1'b0;
            ready_d[alloc_p] = 1'b0;
        end
        if (miss) begin
            free_d  = free_d | amask_q[rn.br_tag_i];
            ready_d = ready_d | amask_q[rn.br_tag_i];
        end
    end

    always_comb begin : ckpt_next
        ckv_d   = ckv_q;
        amask_d = amask_q;
        dep_d   = dep_q;
        drop    = '0;
        if (hit)  drop[rn.br_tag_i] = 1'b1;
        if (miss) begin
            drop = dep_q[rn.br_tag_i];
            drop[rn.br_tag_i] = 1'b1;
        end
        for (int i = 0; i < CKPTS; i++) begin
            if (ckv_q[i] && rd_en) amask_d[i][alloc_p] = 1'b1;
        end
        if (br_en) begin
            ckv_d[ck_k]   = 1'b1;
            amask_d[ck_k] = '0;
            dep_d[ck_k]   = '0;
            for (int i = 0; i < CKPTS; i++) begin
                if (ckv_q[i] && (TW'(i) != ck_k)) dep_d[i][ck_k] = 1'b1;
            end
        end
        // Released slots leave no trace in the others' dependency masks.
        for (int s = 0; s < CKPTS; s++) begin
            if (drop[s]) begin
                ckv_d[s]   = 1'b0;
                amask_d[s] = '0;
                dep_d[s]   = '0;
                for (int i = 0; i < CKPTS; i++) dep_d[i][s] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
            for (int i = 0; i < PHYS_REGS; i++) free_q[i] <= (i >= ARCH_REGS);
            ready_q <= '1;
            ckv_q   <= '0;
            for (int k = 0; k < CKPTS; k++) begin
                amask_q[k] <= '0;
                dep_q[k]   <= '0;
                for (int i = 0; i < ARCH_REGS; i++) ckmap_q[k][i] <= '0;
            end
        end else begin
            map_q   <= map_d;
            free_q  <= free_d;
            ready_q <= ready_d;
            ckv_q   <= ckv_d;
            ckmap_q <= ckmap_d;
            amask_q <= amask_d;
            dep_q   <= dep_d;
        end
    end
endmodule

// File: doc/rename_ckpt.md
# rename_ckpt

Parametrised register-rename stage with multi-level branch checkpointing. It maps architectural source/destination registers to physical registers through a rename map, free list and ready table. It supports up to CKPTS unresolved branches with out-of-order resolution and single-cycle mispredict recovery. It sits between decode and dispatch/ROB and succeeds the single-branch rename unit.

## Interface
- ARCH_REGS, 32, architectural registers; AW = $clog2(ARCH_REGS)
- PHYS_REGS, 64, physical registers (must exceed ARCH_REGS); PW = $clog2(PHYS_REGS)
- CKPTS, 4, branch checkpoint slots; TW = max(1, $clog2(CKPTS))
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- dinstr_valid_i, dinstr_is_branch_i  in  1  decoded instruction valid / is branch
- dinstr_rd_valid_i, dinstr_rs1_valid_i, dinstr_rs2_valid_i  in  1  operand valids
- dinstr_rd_idx_i, dinstr_rs1_idx_i, dinstr_rs2_idx_i  in  AW  architectural indices
- wb_valid_i / wb_idx_i  in  1 / PW  physical register written back; becomes ready
- commit_valid_i / commit_idx_i  in  1 / PW  committed instruction's old physical rd; returned to free list
- br_valid_i / br_hit_i / br_tag_i  in  1 / 1 / TW  branch resolution: hit = predicted correctly
- rinstr_valid_o  out  1  renamed instruction valid
- rinstr_rd_valid_o / rinstr_rd_idx_o / rinstr_rd_old_idx_o  out  1 / PW / PW  new and previous mapping of rd
- rinstr_rs1_valid_o, rinstr_rs1_idx_o, rinstr_rs1_ready_o  out  1 / PW / 1  (rs2 identical)
- rinstr_br_valid_o / rinstr_br_tag_o  out  1 / TW  checkpoint taken, its tag
- rn_full_o  out  1  stall: no free physical register or no free checkpoint

## Operation
- Reset: map[i]=i; ready all 1; free = {ARCH_REGS..PHYS_REGS-1}; all checkpoints invalid; outputs valid=0, rn_full_o=0.
- Accept = dinstr_valid_i & !rn_full_o & !(br_valid_i & !br_hit_i). rinstr_valid_o = accept. Index/ready outputs are don't-care when their valid is 0.
- rn_full_o is derived only from registered state: free count == 0 OR all CKPTS slots valid. It stalls non-branches too.
- Sources: idx = map[rs]; ready = ready[idx] | (wb_valid_i & wb_idx_i==idx). Sources read the map before the same instruction's rd update (rs1==rd returns the old mapping).
- x0: rd_idx 0 is treated as rd invalid (rinstr_rd_valid_o=0, no allocation). Source 0 gives idx 0, ready 1. Physical 0 is never freed or allocated.
- Destination: allocate the lowest-index free physical register P. rd_old_idx = map[rd]. At clock edge: map[rd]=P, ready[P]=0, free[P]=0. Set P in the alloc-mask of every checkpoint valid before this cycle.
- Branch (accepted, is_branch): take the lowest free slot k and output tag k. Store a copy of map after this instruction's rd update. alloc_mask[k]=0. Mark k younger in the dependency mask of every other valid slot.
- Hit on valid tag j: slot j invalid, alloc_mask[j] cleared, bit j dropped from other dependency masks.
- Miss on valid tag j: map = ckpt[j]; free |= alloc_mask[j]; ready set for those registers. Slot j and all slots younger than j become invalid. The same-cycle dinstr is dropped.
- Resolution naming an invalid tag: ignored.
- Writeback: ready[wb_idx_i]=1 at edge. Commit: free[commit_idx_i]=1, ready=1 at edge (ignored for idx 0).

## Timing
- Rename is combinational, 0-cycle latency: outputs valid in the same cycle as dinstr_i. All state updates at posedge clk_i.
- Freed registers (commit or miss) and released checkpoints are usable the cycle after; rn_full_o deasserts one cycle after the freeing event.
- Writeback bypasses to source ready in the same cycle.
- Miss takes priority over a same-cycle rename. A hit and a branch allocation may coincide; the released slot is not reused that cycle.
- Commit and allocation in the same cycle: the freed register is not the one allocated.
- Reset asserted mid-operation: immediate return to reset state, outputs valid=0.

## Test plan
- Reset; rd=1,rs1=2,rs2=3 -> rd 32, old 1, rs1 2/ready, rs2 3/ready. Next rs1=1 -> 32 not ready. Same cycle wb 32 -> ready 1.
- 32 rd allocations, no commit -> phys 32..63, then rn_full_o=1 and valid dinstr yields rinstr_valid_o=0. Commit 5 -> full drops next cycle, next rd gets 5.
- rd=1->32; branch -> tag 0; rd=4->33; rd=4->34 (old 33); miss tag 0 -> rs1=4 reads 4 ready, rs1=1 reads 32, next rd gets 33.
- Branch A tag 0; rd=2->32; branch B tag 1; rd=3->33. Hit 0, then miss 1 -> x2=32, x3=3, 33 free, no slots valid.
- Four unresolved branches -> rn_full_o=1. Hit tag 2 -> full clears next cycle, next branch gets tag 2. Miss with valid dinstr same cycle -> rinstr_valid_o=0.
- rd=0, rs1=0 -> rd_valid 0, no allocation, rs1 idx 0 ready 1. Reset mid-sequence -> map identity, rn_full_o=0.
